cpu_flag_ctrl: RTL and testbench

//  Owns and sequences the CPU status flags C (carry), Z (zero) and B (borrow).

---
 rtl/cpu_flag_ctrl_if.sv | 46 ++++
 rtl/cpu_flag_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cpu_flag_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_flag_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_flag_ctrl_if
//  Bundles the request and status signals of the CPU flag controller.
//  Clock (CLK) and reset (RST) stay plain ports on the controller itself.
//
//  Requests (master -> slave):
//   alu_valid / alu_mask[2:0] / alu_flags[2:0] : masked ALU flag update {C,Z,B}
//   sw_we / sw_flags[2:0]                      : software write of all flags
//   push / pop                                 : shadow stack save / restore
//   err_clr                                    : clear sticky stack error
//   cond_sel[2:0]                              : branch condition select
//  Status (slave -> master):
//   C, Z, B                                    : registered flags
//   cond_true                                  : selected condition holds
//   stack_full / stack_empty / stack_err       : shadow stack status
// ---------------------------------------------------------------------------
interface cpu_flag_ctrl_if;
    logic       alu_valid;
    logic [2:0] alu_mask;
    logic [2:0] alu_flags;
    logic       sw_we;
    logic [2:0] sw_flags;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [2:0] cond_sel;
    logic       C;
    logic       Z;
    logic       B;
    logic       cond_true;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    modport master (
        output alu_valid, alu_mask, alu_flags, sw_we, sw_flags,
               push, pop, err_clr, cond_sel,
        input  C, Z, B, cond_true, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  alu_valid, alu_mask, alu_flags, sw_we, sw_flags,
               push, pop, err_clr, cond_sel,
        output C, Z, B, cond_true, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/cpu_flag_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_flag_ctrl
//  Owns the CPU status flags C (carry), Z (zero) and B (borrow), arbitrates
//  their writers (stack restore > software write > ALU update), keeps a LIFO
//  shadow stack for interrupt entry/return and evaluates branch conditions.
//
//  Parameters:
//   DEPTH : shadow stack entries (>= 2)
//  Ports:
//   CLK   : system clock, all state changes on posedge
//   RST   : synchronous active-high reset, overrides every request
//   bus   : cpu_flag_ctrl_if.slave (requests in, flags/status out)
//
//  Build option CPU_FLAG_STACK_EN:
//   defined     -> shadow stack with push/pop/err_clr and live stack status
//   not defined -> no stack storage, push/pop/err_clr ignored,
//                  stack_full=0, stack_empty=1, stack_err=0
// ---------------------------------------------------------------------------
module cpu_flag_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RST,
    cpu_flag_ctrl_if.slave bus
);

    // Flags are kept packed as {C,Z,B}.
    logic [2:0] flags_r;
    logic [2:0] flags_src_s;
    logic [2:0] flags_nxt_s;

    // Branch condition table over the registered flags.
    function automatic logic cond_eval(input logic [2:0] sel, input logic [2:0] f);
        logic res;
        case (sel)
            3'b000:  res = 1'b1;
            3'b001:  res = f[2];
            3'b010:  res = ~f[2];
            3'b011:  res = f[1];
            3'b100:  res = ~f[1];
            3'b101:  res = f[0];
            3'b110:  res = ~f[0];
            3'b111:  res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Non-stack flag source: software write wins whole, ALU merges under its mask.
    always_comb begin
        flags_src_s = flags_r;
        if (bus.sw_we) begin
            flags_src_s = bus.sw_flags;
        end else if (bus.alu_valid) begin
            flags_src_s = (flags_r & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);
        end else begin
            flags_src_s = flags_r;
        end
    end

`ifdef CPU_FLAG_STACK_EN
    localparam int                 PTR_W   = $clog2(DEPTH + 1);
    localparam int                 IDX_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   SP_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]   SP_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]   SP_ZERO = PTR_W'(0);

    logic [2:0]       stack_r [DEPTH];
    logic [PTR_W-1:0] sp_r;
    logic [PTR_W-1:0] sp_nxt_s;
    logic [PTR_W-1:0] sp_dec_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             fault_s;

    assign full_s   = (sp_r == SP_FULL);
    assign empty_s  = (sp_r == SP_ZERO);
    assign sp_dec_s = sp_r - SP_ONE;

    // Classify the stack request: a collision, overflow or underflow is a fault
    // and leaves the stack untouched.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        fault_s   = 1'b0;
        if (bus.push && bus.pop) begin
            fault_s = 1'b1;
        end else if (bus.push) begin
            if (full_s) begin
                fault_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
        end else if (bus.pop) begin
            if (empty_s) begin
                fault_s = 1'b1;
            end else begin
                pop_ok_s = 1'b1;
            end
        end else begin
            fault_s = 1'b0;
        end
    end

    // Next flags, pointer and sticky error; a valid pop overrides the other writers,
    // and a new fault beats a same-cycle clear.
    always_comb begin
        flags_nxt_s = flags_src_s;
        sp_nxt_s    = sp_r;
        err_nxt_s   = err_r;
        if (pop_ok_s) begin
            flags_nxt_s = stack_r[sp_dec_s[IDX_W-1:0]];
            sp_nxt_s    = sp_dec_s;
        end else if (push_ok_s) begin
            sp_nxt_s    = sp_r + SP_ONE;
        end else begin
            sp_nxt_s    = sp_r;
        end
        if (fault_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Stack storage: saves the pre-update flags; contents are not cleared on reset.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok_s) begin
            stack_r[sp_r[IDX_W-1:0]] <= flags_r;
        end
    end

    // Stack pointer and sticky error register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_r  <= SP_ZERO;
            err_r <= 1'b0;
        end else begin
            sp_r  <= sp_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
    assign bus.stack_err   = err_r;
`else
    // Stack requests have no effect in this build.
    logic unused_stack_in_s;
    assign unused_stack_in_s = ^{bus.push, bus.pop, bus.err_clr, 1'(DEPTH)};

    // Without a stack the flags follow the software/ALU writers only.
    always_comb begin
        flags_nxt_s = flags_src_s;
    end

    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.stack_err   = 1'b0;
`endif

    // Flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_r <= 3'b000;
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    assign bus.C         = flags_r[2];
    assign bus.Z         = flags_r[1];
    assign bus.B         = flags_r[0];
    // No bypass: the condition sees only flags already registered.
    assign bus.cond_true = cond_eval(bus.cond_sel, flags_r);

endmodule

// File: tb/tb_cpu_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_flag_ctrl
//  Scoreboard bench for cpu_flag_ctrl. The driver applies one request set per
//  cycle, pushes the expected visible state (from a queue-based reference
//  model) and the monitor pops and compares it on the falling edge.
//  Honours CPU_FLAG_STACK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cpu_flag_ctrl;
    localparam int DEPTH = 4;
`ifdef CPU_FLAG_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cpu_flag_ctrl_if bus();

    cpu_flag_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] flags;
        logic       full;
        logic       empty;
        logic       err;
        logic       cond;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model state: flags, the stack as a plain LIFO queue, sticky error.
    bit [2:0] m_flags = 3'b000;
    bit [2:0] m_stk[$];
    bit       m_err   = 1'b0;
    bit       m_known = 1'b0;

    function automatic bit model_cond(input bit [2:0] sel, input bit [2:0] f);
        bit c, z, b;
        c = f[2]; z = f[1]; b = f[0];
        case (sel)
            3'd0:    return 1'b1;
            3'd1:    return c;
            3'd2:    return !c;
            3'd3:    return z;
            3'd4:    return !z;
            3'd5:    return b;
            3'd6:    return !b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    exp_t e_mon;
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            check("flags", {5'b00000, bus.C, bus.Z, bus.B}, {5'b00000, e_mon.flags});
            check("stack_full", {7'b0000000, bus.stack_full}, {7'b0000000, e_mon.full});
            check("stack_empty", {7'b0000000, bus.stack_empty}, {7'b0000000, e_mon.empty});
            check("stack_err", {7'b0000000, bus.stack_err}, {7'b0000000, e_mon.err});
            check("cond_true", {7'b0000000, bus.cond_true}, {7'b0000000, e_mon.cond});
        end
    end

    // Apply one cycle of requests: record what must be visible during this cycle,
    // then advance the model across the coming edge.
    task automatic drive(input bit rst, input bit av, input bit [2:0] am, input bit [2:0] af,
                         input bit sw, input bit [2:0] sf, input bit ps, input bit pp,
                         input bit ec, input bit [2:0] cs);
        exp_t     e;
        bit [2:0] nf;
        bit       restored;
        bit       fault;
        RST           = rst;
        bus.alu_valid = av;
        bus.alu_mask  = am;
        bus.alu_flags = af;
        bus.sw_we     = sw;
        bus.sw_flags  = sf;
        bus.push      = ps;
        bus.pop       = pp;
        bus.err_clr   = ec;
        bus.cond_sel  = cs;
        if (m_known) begin
            e.flags = m_flags;
            e.full  = STACK_EN && (m_stk.size() == DEPTH);
            e.empty = !STACK_EN || (m_stk.size() == 0);
            e.err   = m_err;
            e.cond  = model_cond(cs, m_flags);
            sb.push_back(e);
        end
        if (rst) begin
            m_flags = 3'b000;
            m_stk.delete();
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            restored = 1'b0;
            fault    = 1'b0;
            nf       = m_flags;
            if (STACK_EN) begin
                if (ps && pp) begin
                    fault = 1'b1;
                end else if (ps) begin
                    if (m_stk.size() == DEPTH) fault = 1'b1;
                    else m_stk.push_back(m_flags);
                end else if (pp) begin
                    if (m_stk.size() == 0) begin
                        fault = 1'b1;
                    end else begin
                        nf = m_stk.pop_back();
                        restored = 1'b1;
                    end
                end
                if (fault) m_err = 1'b1;
                else if (ec) m_err = 1'b0;
            end
            if (!restored) begin
                if (sw) nf = sf;
                else if (av) begin
                    for (int k = 0; k < 3; k++) if (am[k]) nf[k] = af[k];
                end
            end
            m_flags = nf;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input bit [2:0] cs);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, cs);
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_mask = 3'b000; bus.alu_flags = 3'b000;
        bus.sw_we = 1'b0; bus.sw_flags = 3'b000; bus.push = 1'b0; bus.pop = 1'b0;
        bus.err_clr = 1'b0; bus.cond_sel = 3'b000;
        @(posedge CLK);
        #1;
        // Reset with every request active.
        drive(1'b1, 1'b1, 3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b000);
        idle(3'b000);
        // Masked ALU update, then condition checks on Z and B.
        drive(1'b0, 1'b1, 3'b101, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001);
        idle(3'b011);
        idle(3'b101);
        // Software write beats ALU update.
        drive(1'b0, 1'b1, 3'b111, 3'b101, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(3'b100);
        // Save, overwrite, restore.
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 3'b010);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b110);
        idle(3'b001);
        // Overflow: five pushes, each with a new software value.
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'(i + 1), 1'b1, 1'b0, 1'b0, 3'(i));
        idle(3'b000);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
        // Underflow: five pops, the last one faults with flags unchanged.
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'(i + 1));
        idle(3'b011);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
        // Push/pop collision at depth two, plus a fault arriving with err_clr.
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 3'b111, 3'b010, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000);
        idle(3'b011);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000);
        idle(3'b000);
        // Randomized traffic; push/pop bias alternates so the stack reaches both ends.
        for (int i = 0; i < 3000; i++) begin
            bit hi_push;
            hi_push = ((i / 150) % 2) == 0;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 7) < (hi_push ? 4 : 1),
                  $urandom_range(0, 7) < (hi_push ? 1 : 4),
                  $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
        end
        idle(3'b000);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
